md_sched: RTL

- Sequencing controller for the pipeline's multiply/divide (HI/LO) unit.
- Accepts HI/LO-class instructions issued from the E stage and launches the mult/div datapath.
- Tracks the unit's fixed multi-cycle latency and generates the HI/LO write enables.
- Drives the D-stage stall, so no HI/LO-class instruction leaves D while the unit is launching or busy. Forwarding of HI/LO is not needed because of this stall.

---
 rtl/md_sched.sv | 126 ++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// md_sched: sequencing controller for the multiply/divide (HI/LO) unit.
//
// Accepts MULT/MULTU/DIV/DIVU from the E stage and launches the datapath.
// It counts the fixed latency of the unit and pulses the HI/LO write enables
// when the result is ready. It applies MTHI/MTLO directly while the unit is
// idle. It stalls D so that no HI/LO-class instruction leaves D while the unit
// is launching or busy, which is why no HI/LO forwarding is needed.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   md_op_E    in   E-stage op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                   5 MTHI, 6 MTLO, 7 reserved (treated as none)
//   flush      in   flush of E and younger stages
//   md_use_D   in   D-stage instruction is HI/LO-class
//   md_start   out  one-cycle launch pulse (combinational)
//   md_sign    out  signed op (MULT/DIV), valid with md_start
//   md_div     out  divide op (DIV/DIVU), valid with md_start
//   busy       out  unit is computing (registered)
//   hi_we      out  HI write enable
//   lo_we      out  LO write enable
//   stall_D    out  freeze PC/F/D and bubble E
//   stall_cnt  out  32-bit count of stalled cycles (only with MD_STALL_CNT_EN)
//
// Optional feature macro: MD_STALL_CNT_EN adds the stall_cnt output.
module md_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] md_op_E,
  input  logic       flush,
  input  logic       md_use_D,
  output logic       md_start,
  output logic       md_sign,
  output logic       md_div,
  output logic       busy,
  output logic       hi_we,
  output logic       lo_we,
`ifdef MD_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic       stall_D
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             op_mul_s;
  logic             op_dv_s;
  logic             idle_ok_s;
  logic             acc_s;
  logic             done_s;

  // Decode the E-stage op, accept/done conditions and all combinational outputs.
  // Everything is gated by reset so the outputs stay 0 while reset is held.
  always_comb begin
    op_mul_s  = (md_op_E == 3'd1) || (md_op_E == 3'd2);
    op_dv_s   = (md_op_E == 3'd3) || (md_op_E == 3'd4);
    idle_ok_s = reset && (state_r == ST_IDLE) && !flush;
    acc_s     = idle_ok_s && (op_mul_s || op_dv_s);
    // Result is ready in the last busy cycle; a reset here aborts the write.
    done_s    = reset && (state_r == ST_BUSY) && (cnt_r == {CNT_W{1'b0}});
    md_start  = acc_s;
    md_sign   = reset && ((md_op_E == 3'd1) || (md_op_E == 3'd3));
    md_div    = reset && op_dv_s;
    hi_we     = done_s || (idle_ok_s && (md_op_E == 3'd5));
    lo_we     = done_s || (idle_ok_s && (md_op_E == 3'd6));
    // Launch cycle counts as occupied so a younger HI/LO op never reaches E.
    stall_D   = md_use_D && (busy_r || acc_s);
  end

  assign busy = busy_r;

  // IDLE/BUSY state machine with latency down-counter; ops arriving while
  // BUSY (and flushes while BUSY) are deliberately ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (acc_s) begin
            state_r <= ST_BUSY;
            busy_r  <= 1'b1;
            cnt_r   <= op_dv_s ? DIV_LOAD : MULT_LOAD;
          end
        end
        ST_BUSY: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef MD_STALL_CNT_EN
  // Free-running count of stalled cycles; wraps naturally, unaffected by flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
    end else if (stall_D) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
